barrel_shifter_left_pipe: RTL

- Pipelined logical left barrel shifter: shifts toward the MSB and fills vacated LSBs with zero.
- Complements the existing combinational right shifter. Together they give the ALU both shift directions.
- One log2 stage per clock, so large N closes timing.
- Valid/ready handshake on both sides, with full-pipeline backpressure.

---
 rtl/barrel_shifter_left_pipe_if.sv | 35 +++
 rtl/barrel_shifter_left_pipe.sv | 116 +++++++++++
 2 files changed

// File: rtl/barrel_shifter_left_pipe_if.sv
// Operand/result handshake bundle for barrel_shifter_left_pipe.
// Optional Rotate signal present only when BARREL_SHIFTER_ROTATE_EN is defined.
interface barrel_shifter_left_pipe_if #(
    parameter int N = 32
);
    localparam int S = $clog2(N);

    logic         In_Valid;
    logic         In_Ready;
    logic [N-1:0] Input;
    logic [S-1:0] Shift_Val;
    logic         Out_Valid;
    logic         Out_Ready;
    logic [N-1:0] Result;
    logic         Busy;
`ifdef BARREL_SHIFTER_ROTATE_EN
    logic         Rotate;
`endif

    modport slave (
        input  In_Valid, Input, Shift_Val, Out_Ready,
`ifdef BARREL_SHIFTER_ROTATE_EN
        input  Rotate,
`endif
        output In_Ready, Out_Valid, Result, Busy
    );

    modport master (
        output In_Valid, Input, Shift_Val, Out_Ready,
`ifdef BARREL_SHIFTER_ROTATE_EN
        output Rotate,
`endif
        input  In_Ready, Out_Valid, Result, Busy
    );
endinterface

// File: rtl/barrel_shifter_left_pipe.sv
// Pipelined logical left barrel shifter, one log2 stage per clock, valid/ready on both sides.
// Define BARREL_SHIFTER_ROTATE_EN to add a per-operation rotate-left mode.
module barrel_shifter_left_pipe #(
    parameter int N = 32
) (
    input logic                      Clk,
    input logic                      Reset_n,
    barrel_shifter_left_pipe_if.slave bus
);
    localparam int S = $clog2(N);

    logic         w_advance;
    logic [S-1:0] w_valid_vec;
    logic [N-1:0] w_last_data;

    function automatic logic [N-1:0] shift_stage(
        input logic [N-1:0] data,
        input logic         en,
        input int           amt,
        input logic         rot
    );
        logic [N-1:0] res;
        if (!en) begin
            res = data;
        end else if (rot) begin
            res = (data << amt) | (data >> (N - amt));
        end else begin
            res = data << amt;
        end
        return res;
    endfunction

    // The whole pipe moves as one: any free slot at the output lets everything advance.
    assign w_advance     = bus.Out_Ready | ~bus.Out_Valid;
    assign bus.In_Ready  = w_advance;
    assign bus.Busy      = |w_valid_vec;
    assign bus.Out_Valid = w_valid_vec[S-1];
    assign bus.Result    = w_last_data;

    for (genvar k = 0; k < S; k++) begin : g_stage
        localparam int AMT = 1 << (S - 1 - k);

        logic [N-1:0] w_src_data;
        logic         w_src_valid;
        logic [S-1-k:0] w_src_shamt;
        logic         w_src_rot;
        logic [N-1:0] w_shifted;
        logic [N-1:0] r_data;
        logic         r_valid;

        if (k == 0) begin : g_src
            assign w_src_data  = bus.Input;
            assign w_src_valid = bus.In_Valid;
            assign w_src_shamt = bus.Shift_Val;
`ifdef BARREL_SHIFTER_ROTATE_EN
            assign w_src_rot   = bus.Rotate;
`else
            assign w_src_rot   = 1'b0;
`endif
        end else begin : g_src
            assign w_src_data  = g_stage[k-1].r_data;
            assign w_src_valid = g_stage[k-1].r_valid;
            assign w_src_shamt = g_stage[k-1].g_rem.r_rem;
`ifdef BARREL_SHIFTER_ROTATE_EN
            assign w_src_rot   = g_stage[k-1].g_rem.r_rot;
`else
            assign w_src_rot   = 1'b0;
`endif
        end

        // The MSB of the incoming shift bits belongs to this stage.
        assign w_shifted = shift_stage(w_src_data, w_src_shamt[S-1-k], AMT, w_src_rot);

        // Stage register; a bubble moves only its valid bit and leaves data stale.
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_data  <= '0;
                r_valid <= 1'b0;
            end else if (w_advance) begin
                r_valid <= w_src_valid;
                if (w_src_valid) begin
                    r_data <= w_shifted;
                end else begin
                    r_data <= r_data;
                end
            end
        end

        if (k < S - 1) begin : g_rem
            logic [S-2-k:0] r_rem;
`ifdef BARREL_SHIFTER_ROTATE_EN
            logic           r_rot;
`endif
            // Carries the still-unconsumed shift bits (and mode) to the later stages.
            always_ff @(posedge Clk or negedge Reset_n) begin
                if (!Reset_n) begin
                    r_rem <= '0;
`ifdef BARREL_SHIFTER_ROTATE_EN
                    r_rot <= 1'b0;
`endif
                end else if (w_advance && w_src_valid) begin
                    r_rem <= w_src_shamt[S-2-k:0];
`ifdef BARREL_SHIFTER_ROTATE_EN
                    r_rot <= w_src_rot;
`endif
                end
            end
        end

        assign w_valid_vec[k] = r_valid;

        if (k == S - 1) begin : g_out
            assign w_last_data = r_data;
        end
    end
endmodule
